decomp_single128: RTL

DECOMP_SINGLE128 -- requirements
Module: decomp_single128

---
 rtl/decomp_single128_if.sv | 23 ++
 rtl/decomp_single128.sv | 100 ++++++++++
 2 files changed

// File: rtl/decomp_single128_if.sv
// rtl/decomp_single128_if.sv - count-in / beat-out handshake bundle for decomp_single128
interface decomp_single128_if #(
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       comp_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_col0;
    logic             out_last;
    logic             out_err;

    modport master (
        output in_valid, comp_in, out_ready,
        input  in_ready, out_valid, out_col0, out_last, out_err
    );

    modport slave (
        input  in_valid, comp_in, out_ready,
        output in_ready, out_valid, out_col0, out_last, out_err
    );
endinterface

// File: rtl/decomp_single128.sv
// rtl/decomp_single128.sv - expands a column count into a 128-bit thermometer column sent as OUT_W-bit beats
module decomp_single128 #(
    parameter int OUT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    decomp_single128_if.slave  bus
);
    localparam int BEATS = 128 / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [BW-1:0]    beat_nxt;
    logic [7:0]       csat_q, csat_d;
    logic [7:0]       csat_in;
    logic             err_q, err_d;
    logic             last_q, last_d;
    logic [OUT_W-1:0] col_q, col_d;

    // Slice k of the thermometer column: the low r bits set, r clamped to 0..OUT_W
    function automatic logic [OUT_W-1:0] beat_val(input logic [7:0] c, input logic [BW-1:0] k);
        int r;
        r = int'(c) - int'(k) * OUT_W;
        if (r <= 0)
            return '0;
        if (r >= OUT_W)
            return '1;
        return ~({OUT_W{1'b1}} << r);
    endfunction

    assign csat_in  = (bus.comp_in > 8'd128) ? 8'd128 : bus.comp_in;
    assign beat_nxt = beat_q + 1'b1;

    // Next-state logic: latch a count in IDLE, walk the beats in SEND; beat data is precomputed into registers
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        csat_d  = csat_q;
        err_d   = err_q;
        last_d  = last_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SEND;
                    beat_d  = '0;
                    csat_d  = csat_in;
                    err_d   = (bus.comp_in > 8'd128);
                    col_d   = beat_val(csat_in, '0);
                    last_d  = (LAST_BEAT == '0);
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        err_d   = 1'b0;
                        last_d  = 1'b0;
                        col_d   = '0;
                    end else begin
                        beat_d  = beat_nxt;
                        col_d   = beat_val(csat_q, beat_nxt);
                        last_d  = (beat_nxt == LAST_BEAT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset that aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            csat_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            csat_q  <= csat_d;
            err_q   <= err_d;
            last_q  <= last_d;
            col_q   <= col_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_col0  = col_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;
endmodule
